// File: rtl/lsu_pkg.sv
// Shared types and opcode decode for the MEM-stage load/store unit.
package lsu_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {IDLE, REQ, DONE} lsu_state_t;
    typedef enum logic [1:0] {BYTE, HALF, WORD} lsu_width_t;

    typedef struct packed {
        logic       memop;
        logic       store;
        lsu_width_t wid;
        logic       sgn;
    } lsu_dec_t;

    function automatic lsu_dec_t lsu_decode(input logic [5:0] op);
        lsu_dec_t d;
        d = '{memop: 1'b1, store: 1'b0, wid: WORD, sgn: 1'b0};
        unique case (op)
            OP_LB:   begin d.wid = BYTE; d.sgn = 1'b1; end
            OP_LH:   begin d.wid = HALF; d.sgn = 1'b1; end
            OP_LW:   d.wid = WORD;
            OP_LBU:  d.wid = BYTE;
            OP_LHU:  d.wid = HALF;
            OP_SB:   begin d.wid = BYTE; d.store = 1'b1; end
            OP_SH:   begin d.wid = HALF; d.store = 1'b1; end
            OP_SW:   begin d.wid = WORD; d.store = 1'b1; end
            default: d.memop = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/acknowledge bus between the LSU and memory.
interface mem_stage_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_lane.sv
// Byte-lane steering: enables, store replication, load extract/extend.
module lsu_lane
    import lsu_pkg::*;
(
    input  lsu_width_t  wid,
    input  logic        sgn,
    input  logic [1:0]  a,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata_in,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] rdata_ext
);
    logic [7:0]  b_src;
    logic [15:0] h_src;

    always_comb begin
        b_src     = 8'(rdata_in >> {a, 3'b000});
        h_src     = 16'(rdata_in >> {a[1], 4'b0000});
        be        = 4'b1111;
        wdata     = wdata_in;
        rdata_ext = rdata_in;
        unique case (wid)
            BYTE: begin
                be        = 4'b0001 << a;
                wdata     = {4{wdata_in[7:0]}};
                rdata_ext = {{24{sgn & b_src[7]}}, b_src};
            end
            HALF: begin
                be        = 4'b0011 << {a[1], 1'b0};
                wdata     = {2{wdata_in[15:0]}};
                rdata_ext = {{16{sgn & h_src[15]}}, h_src};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one blocking bus transaction per memop.
// Optional misalignment traps: define LSU_ALIGN_CHECK_EN.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr,
    input  logic [31:0]       alu_addr,
    input  logic [DATA_W-1:0] rt_data,
    mem_stage_lsu_if.master   bus,
    output logic              stall,
    output logic [DATA_W-1:0] ld_data,
    output logic              ld_valid,
    output logic              exc_adel,
    output logic              exc_ades
);
    lsu_state_t        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       ld_data_q, ld_data_d;

    lsu_dec_t    dec;
    logic        misal;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;
    logic        unused_instr;

    assign dec          = lsu_decode(instr[31:26]);
    assign unused_instr = ^instr[25:0];

`ifdef LSU_ALIGN_CHECK_EN
    assign misal = dec.memop &&
                   ((dec.wid == WORD && alu_addr[1:0] != 2'b00) ||
                    (dec.wid == HALF && alu_addr[0]));
`else
    assign misal = 1'b0;
`endif

    // instr/alu_addr are frozen by stall, so one lane serves both phases
    lsu_lane u_lane (
        .wid       (dec.wid),
        .sgn       (dec.sgn),
        .a         (alu_addr[1:0]),
        .wdata_in  (rt_data),
        .rdata_in  (bus.mem_rdata),
        .be        (lane_be),
        .wdata     (lane_wdata),
        .rdata_ext (lane_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            ld_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            ld_data_q   <= ld_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (dec.memop) state_d = misal ? DONE : REQ;
            REQ:     if (bus.mem_ack) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        ld_data_d   = ld_data_q;
        unique case (state_q)
            IDLE: if (dec.memop && !misal) begin
                mem_req_d   = 1'b1;
                mem_we_d    = dec.store;
                mem_addr_d  = ADDR_W'({alu_addr[31:2], 2'b00});
                mem_be_d    = lane_be;
                mem_wdata_d = lane_wdata;
            end
            REQ: if (bus.mem_ack) begin
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
                if (!dec.store) ld_data_d = lane_rdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        stall    = 1'b0;
        ld_valid = 1'b0;
        exc_adel = 1'b0;
        exc_ades = 1'b0;
        unique case (state_q)
            IDLE: stall = dec.memop;
            REQ:  stall = 1'b1;
            DONE: begin
                ld_valid = dec.memop && !dec.store && !misal;
                exc_adel = misal && !dec.store;
                exc_ades = misal && dec.store;
            end
            default: ;
        endcase
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign ld_data       = ld_data_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized bench for mem_stage_lsu against a transaction-level model.
module tb_mem_stage_lsu;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = '0;
    logic [31:0] alu_addr = '0;
    logic [31:0] rt_data = '0;
    logic        stall;
    logic [31:0] ld_data;
    logic        ld_valid;
    logic        exc_adel;
    logic        exc_ades;
    int          checks = 0;
    int          errors = 0;

    mem_stage_lsu_if #(.ADDR_W(32)) bus ();

    mem_stage_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .instr    (instr),
        .alu_addr (alu_addr),
        .rt_data  (rt_data),
        .bus      (bus),
        .stall    (stall),
        .ld_data  (ld_data),
        .ld_valid (ld_valid),
        .exc_adel (exc_adel),
        .exc_ades (exc_ades)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int op_bytes(input logic [5:0] op);
        case (op)
            6'h20, 6'h24, 6'h28: return 1;
            6'h21, 6'h25, 6'h29: return 2;
            6'h23, 6'h2B:        return 4;
            default:             return 0;
        endcase
    endfunction

    // One instruction through MEM: bench is the pipeline and the memory.
    task automatic run_op(input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input int delay,
                          input logic [31:0] rd);
        int          nb;
        bit          st, sg, mis, done;
        int          nstall, nreq, off;
        logic [1:0]  a;
        logic [3:0]  e_be;
        logic [31:0] e_wd, e_ld;
        logic [63:0] m;
        nb  = op_bytes(op);
        st  = (op == 6'h28 || op == 6'h29 || op == 6'h2B);
        sg  = (op == 6'h20 || op == 6'h21);
        a   = addr[1:0];
        mis = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
        mis = (nb == 4 && a != 0) || (nb == 2 && a[0]);
`endif
        e_be = (nb == 4) ? 4'hF : (nb == 2) ? (a[1] ? 4'hC : 4'h3)
                                            : 4'(1 << a);
        e_wd = (nb == 1) ? wd[7:0] * 32'h0101_0101
             : (nb == 2) ? wd[15:0] * 32'h0001_0001 : wd;
        off  = (nb == 1) ? int'(a) : (nb == 2) ? int'(a & 2'b10) : 0;
        m    = (64'd1 << (8 * nb)) - 64'd1;
        e_ld = (rd >> (8 * off)) & m[31:0];
        if (sg && nb > 0 && e_ld[8*nb-1]) e_ld = e_ld | ~m[31:0];

        instr    = {op, 26'($urandom)};
        alu_addr = addr;
        rt_data  = wd;
        nstall   = 0;
        nreq     = 0;
        done     = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (stall) begin
                nstall++;
                if (nstall == 1) begin
                    chk("req_idle", 32'(bus.mem_req), 0);
                end else begin
                    chk("req_held", 32'(bus.mem_req), 1);
                    chk("we", 32'(bus.mem_we), 32'(st));
                    chk("addr", bus.mem_addr, addr & ~32'h3);
                    chk("be", 32'(bus.mem_be), 32'(e_be));
                    if (st) chk("wdata", bus.mem_wdata, e_wd);
                    if (nreq == delay) begin
                        bus.mem_ack   = 1'b1;
                        bus.mem_rdata = rd;
                    end
                    nreq++;
                end
            end else begin
                done = 1'b1;
                chk("req_done", 32'(bus.mem_req), 0);
                if (nb == 0) begin
                    chk("nop_stall", 32'(nstall), 0);
                    chk("nop_ldv", 32'(ld_valid), 0);
                end else if (mis) begin
                    chk("mis_stall", 32'(nstall), 1);
                    chk("mis_ldv", 32'(ld_valid), 0);
                    chk("adel", 32'(exc_adel), 32'(!st));
                    chk("ades", 32'(exc_ades), 32'(st));
                end else begin
                    chk("stall_cyc", 32'(nstall), 32'(delay + 2));
                    chk("ldv", 32'(ld_valid), 32'(!st));
                    chk("exc", 32'({exc_adel, exc_ades}), 0);
                    if (!st) chk("ld_data", ld_data, e_ld);
                end
            end
            @(posedge clk);
            #1;
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom;
        end
        if (!done) chk("timeout", 0, 1);
    endtask

    initial begin
        logic [5:0] op;
        logic [5:0] ops [8];
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};

        repeat (2) @(negedge clk);
        chk("rst_req", 32'(bus.mem_req), 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_be", 32'(bus.mem_be), 0);
        chk("rst_ld", ld_data, 0);
        chk("rst_ldv", 32'(ld_valid), 0);
        chk("rst_stall", 32'(stall), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        run_op(6'h23, 32'h0000_1004, 32'h0, 0, 32'hCAFE_BABE);
        run_op(6'h20, 32'h0000_1003, 32'h0, 1, 32'h80FF_0000);
        run_op(6'h24, 32'h0000_1003, 32'h0, 0, 32'h80FF_0000);
        run_op(6'h29, 32'h0000_2002, 32'h1234_ABCD, 0, 32'h0);
        run_op(6'h2B, 32'h0000_3000, 32'hDEAD_BEEF, 4, 32'h0);
        run_op(6'h23, 32'h0000_1002, 32'h0, 0, 32'h1357_9BDF);
        run_op(6'h21, 32'h0000_1001, 32'h0, 2, 32'h8001_7FFE);
        run_op(6'h00, 32'h0000_0000, 32'h0, 0, 32'h0);

        // reset while a load sits in REQ
        instr    = {6'h23, 26'h0};
        alu_addr = 32'h40;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_req", 32'(bus.mem_req), 1);
        #2 reset = 1'b1;
        #1 chk("async_req", 32'(bus.mem_req), 0);
        chk("async_ldv", 32'(ld_valid), 0);
        instr = '0;
        #1 chk("async_stall", 32'(stall), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        bus.mem_ack = 1'b1;
        @(posedge clk);
        #1 bus.mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray_ldv", 32'(ld_valid), 0);
            chk("stray_req", 32'(bus.mem_req), 0);
        end
        @(posedge clk);
        #1;

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                op = 6'($urandom);
                if (op_bytes(op) != 0) op = 6'h00;
            end else begin
                op = ops[$urandom_range(0, 7)];
            end
            run_op(op, $urandom, $urandom, int'($urandom_range(0, 5)),
                   $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
